// File: rtl/data_mem_unit_pkg.sv
// Shared definitions for the data memory stage: RV32I load/store funct3
// codes, FSM state encodings and access-size decode helpers.
// Imported by data_mem_unit and dmem_lane_align.
package data_mem_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Unsupported encodings (011, 110, 111) fall through to word width.
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      F3_W:        return SZ_W;
      default:     return SZ_W;
    endcase
  endfunction

  // Only LB/LH sign-extend; everything else is zero-extended.
  function automatic logic f3_signed(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H);
  endfunction

endpackage

// File: rtl/data_mem_unit_lane_align.sv
// Purpose: byte-lane steering for the data memory stage (store byte enables
//          and replicated write data; load lane extract with sign/zero extension).
// Latency: purely combinational. Backpressure: none, no handshake.
// Ports: funct3/lane select the access; wdata/rword are the raw store data and
//        array word; be/wdata_sh/rdata_ext are the steered results.
// Half and word accesses ignore the low lane bits, which gives natural-alignment
// masking for free when misaligned accesses are allowed to proceed.
module dmem_lane_align
  import data_mem_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  size_e       sz;
  logic        sgn;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    sz        = f3_size(funct3);
    sgn       = f3_signed(funct3);
    byte_v    = rword[{lane, 3'b000} +: 8];
    half_v    = lane[1] ? rword[31:16] : rword[15:0];
    be        = 4'b1111;
    wdata_sh  = wdata;
    rdata_ext = rword;
    case (sz)
      SZ_B: begin
        be        = 4'b0001 << lane;
        wdata_sh  = {4{wdata[7:0]}};
        rdata_ext = {{24{sgn & byte_v[7]}}, byte_v};
      end
      SZ_H: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_sh  = {2{wdata[15:0]}};
        rdata_ext = {{16{sgn & half_v[15]}}, half_v};
      end
      default: begin
        be        = 4'b1111;
        wdata_sh  = wdata;
        rdata_ext = rword;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Purpose: RISC-V data memory stage; LB/LH/LW/LBU/LHU/SB/SH/SW on an internal word array, RD feeds writeback.
// Latency: req sampled at edge N, array access at edge N+1+WAIT_CYCLES, done pulses the following cycle.
// Backpressure: busy high while an access is in flight; req while busy is dropped, not queued.
// Ports: clk/rst (async active-high); req/we/funct3/addr/wdata request inputs;
//        busy/done/RD/misalign status and load result outputs.
// Config macro MISALIGN_CHECK_EN: when defined, misaligned H/W accesses are
// suppressed and flagged on misalign; otherwise low address bits are masked.
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] RD,
  output logic        misalign
);

  localparam int         DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q;
  logic [2:0]              f3_q;
  logic [ADDR_WIDTH+1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic [31:0]             rd_q;
  logic                    mis_q;
  logic [31:0]             mem_q [DEPTH];

  logic                    accept;
  logic                    access;
  logic                    access_mis;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [3:0]              be;
  logic [31:0]             wdata_sh;
  logic [31:0]             rdata_ext;

  // Upper address bits alias onto the array (wrap modulo depth).
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

  assign accept   = (state_q == ST_IDLE) && req;
  assign access   = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign word_idx = addr_q[ADDR_WIDTH+1:2];

`ifdef MISALIGN_CHECK_EN
  always_comb begin
    access_mis = 1'b0;
    case (f3_size(f3_q))
      SZ_H:    access_mis = addr_q[0];
      SZ_W:    access_mis = (addr_q[1:0] != 2'b00);
      default: access_mis = 1'b0;
    endcase
  end
`else
  assign access_mis = 1'b0;
`endif

  dmem_lane_align u_lane_align (
    .funct3    (f3_q),
    .lane      (addr_q[1:0]),
    .wdata     (wdata_q),
    .rword     (mem_q[word_idx]),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req) state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == 4'd0) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    misalign = (state_q == ST_DONE) && mis_q;
    RD       = rd_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept)                             cnt_d = WAIT_INIT;
    else if (state_q == ST_WAIT && !access) cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        we_q    <= we;
        f3_q    <= funct3;
        addr_q  <= addr[ADDR_WIDTH+1:0];
        wdata_q <= wdata;
      end
      if (access) mis_q <= access_mis;
      if (access && !we_q && !access_mis) rd_q <= rdata_ext;
    end
  end

  // Array is never reset; writes happen only on the access edge, so an
  // access cancelled by reset leaves the contents untouched.
  always_ff @(posedge clk) begin
    if (access && we_q && !access_mis) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

endmodule
